// File: rtl/str_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// str_fifo
//
// Purpose:
//   First-word-fall-through stream buffer for the tvalid/tready/tdata protocol.
//   The receive side drains a producer and the transmit side sources a
//   consumer. Up to DEPTH words can be held between the two sides, so each
//   side can stall independently of the other.
//
// Parameters:
//   DW     data width in bits
//   DEPTH  number of buffered words (power of two, >= 2)
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   rst        synchronous active-high reset
//   rx_tvalid  producer presents a word on rx_tdata
//   rx_tready  FIFO accepts a word this cycle (registered)
//   rx_tdata   receive data
//   tx_tvalid  FIFO presents a word on tx_tdata (registered)
//   tx_tready  consumer accepts the word this cycle
//   tx_tdata   head-of-FIFO data (combinational read of storage)
//   count      number of words currently stored
//   full       count == DEPTH
//   empty      count == 0
// -----------------------------------------------------------------------------
module str_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_tvalid,
  output logic                     rx_tready,
  input  logic [DW-1:0]            rx_tdata,
  output logic                     tx_tvalid,
  input  logic                     tx_tready,
  output logic [DW-1:0]            tx_tdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  // Storage and state.
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rx_tready;
  logic          r_tx_tvalid;

  // Handshake decode.
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;

  // Gating with ~rst keeps the storage untouched by a handshake that happens
  // to coincide with a reset edge; the pointers are reset anyway, so this
  // only matters for keeping the write port quiet.
  assign w_push = rx_tvalid & r_rx_tready & ~rst;
  assign w_pop  = r_tx_tvalid & tx_tready & ~rst;

  // Push and pop together leave the occupancy unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Control state. The ready/valid flags are computed from the next
  // occupancy so that both are registered yet still reflect the transfer
  // that happens at this same edge (no bubble at full or empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_tready <= 1'b0;
      r_tx_tvalid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count     <= w_count_next;
      r_rx_tready <= (w_count_next < LP_DEPTH);
      r_tx_tvalid <= (w_count_next != '0);
    end
  end

  // Storage write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_tdata;
    end
  end

  // Outputs. The head word is read asynchronously so that a word written at
  // one edge is visible right after it; it stays stable while stalled since
  // the read pointer only moves on a pop and the slot it addresses cannot be
  // overwritten until it has been popped.
  assign tx_tdata  = r_mem[r_rd_ptr];
  assign rx_tready = r_rx_tready;
  assign tx_tvalid = r_tx_tvalid;
  assign count     = r_count;
  assign full      = (r_count == LP_DEPTH);
  assign empty     = (r_count == '0);

endmodule

// File: tb/tb_str_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_str_fifo
//
// Purpose:
//   Self-checking bench for str_fifo (DW=32, DEPTH=4). A queue-based model
//   of the buffer predicts the handshakes, occupancy, flags and the order of
//   delivered words. Each scenario lives in its own task and does its own
//   comparisons.
// -----------------------------------------------------------------------------
module tb_str_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_tvalid;
  logic          rx_tready;
  logic [DW-1:0] rx_tdata;
  logic          tx_tvalid;
  logic          tx_tready;
  logic [DW-1:0] tx_tdata;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the queue holds the stored words in order; m_live is
  // set once the FIFO has seen a non-reset edge.
  logic [DW-1:0] q[$];
  bit            m_live = 1'b0;

  always #5 clk = ~clk;

  str_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .rx_tdata  (rx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .tx_tdata  (tx_tdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  function automatic bit m_rx_rdy();
    return m_live && (q.size() < DEPTH);
  endfunction

  function automatic bit m_tx_vld();
    return q.size() > 0;
  endfunction

  // Advances one clock edge and updates the model. Reports whether the model
  // expects a push/pop at that edge, the DUT head data seen just before the
  // edge, and the word the model expects at the head.
  task automatic tick(output bit did_push, output bit did_pop,
                      output logic [DW-1:0] obs, output logic [DW-1:0] exp_head);
    logic [DW-1:0] din;
    did_push = !rst && rx_tvalid && m_rx_rdy();
    did_pop  = !rst && tx_tready && m_tx_vld();
    obs      = tx_tdata;
    exp_head = (q.size() > 0) ? q[0] : '0;
    din      = rx_tdata;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_live = 1'b0;
    end else begin
      if (did_pop) void'(q.pop_front());
      if (did_push) q.push_back(din);
      m_live = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    bit p, o;
    logic [DW-1:0] d, e;
    rst = 1'b1; rx_tvalid = 1'b0; tx_tready = 1'b0; rx_tdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick(p, o, d, e);
      n_tests++;
      if (rx_tready !== 1'b0 || tx_tvalid !== 1'b0 || empty !== 1'b1 ||
          full !== 1'b0 || count !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: rdy=%b vld=%b empty=%b full=%b count=%0d, want 0 0 1 0 0",
                 i, rx_tready, tx_tvalid, empty, full, count);
      end
    end
    rst = 1'b0;
    tick(p, o, d, e);
    n_tests++;
    if (rx_tready !== 1'b1 || tx_tvalid !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b empty=%b, want 1 0 1", rx_tready, tx_tvalid, empty);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    bit p, o;
    logic [DW-1:0] d, e;
    rx_tvalid = 1'b1; rx_tdata = 32'hDEADBEEF; tx_tready = 1'b1;
    tick(p, o, d, e);
    rx_tvalid = 1'b0;
    n_tests++;
    if (tx_tvalid !== 1'b1 || tx_tdata !== 32'hDEADBEEF || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_present: vld=%b data=%h count=%0d, want 1 deadbeef 1", tx_tvalid, tx_tdata, count);
    end
    tick(p, o, d, e);
    n_tests++;
    if (!o || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_pop: pop=%b data=%h, want 1 deadbeef", o, d);
    end
    n_tests++;
    if (empty !== 1'b1 || tx_tvalid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL single_empty: empty=%b vld=%b count=%0d, want 1 0 0", empty, tx_tvalid, count);
    end
    $display("[TB] test_single done");
  endtask

  task automatic test_fill_drain();
    bit p, o;
    logic [DW-1:0] d, e;
    int got;
    tx_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rx_tvalid = 1'b1; rx_tdata = DW'(i);
      tick(p, o, d, e);
    end
    n_tests++;
    if (count !== CW'(4) || full !== 1'b1 || rx_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d full=%b rdy=%b, want 4 1 0", count, full, rx_tready);
    end
    rx_tdata = 32'h5;
    tick(p, o, d, e);
    n_tests++;
    if (count !== CW'(4)) begin
      n_fail++;
      $display("FAIL fill_block: count=%0d, want 4", count);
    end
    tx_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      tick(p, o, d, e);
      if (p) rx_tvalid = 1'b0;
      if (o) begin
        n_tests++;
        if (d !== DW'(got + 1)) begin
          n_fail++;
          $display("FAIL drain_order idx=%0d: got %h, want %h", got, d, got + 1);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 5 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_count: words=%0d empty=%b, want 5 1", got, empty);
    end
    rx_tvalid = 1'b0; tx_tready = 1'b0;
    $display("[TB] test_fill_drain done");
  endtask

  task automatic test_simul();
    bit p, o;
    logic [DW-1:0] d, e;
    tx_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_tvalid = 1'b1; rx_tdata = 32'h100 + DW'(i);
      tick(p, o, d, e);
    end
    rx_tdata = 32'h102; tx_tready = 1'b1;
    tick(p, o, d, e);
    n_tests++;
    if (count !== CW'(2) || !p || !o || d !== 32'h100 || tx_tdata !== 32'h101) begin
      n_fail++;
      $display("FAIL simul_mid: count=%0d push=%b pop=%b popped=%h head=%h, want 2 1 1 100 101",
               count, p, o, d, tx_tdata);
    end
    tx_tready = 1'b0;
    for (int i = 3; i < 5; i++) begin
      rx_tdata = 32'h100 + DW'(i);
      tick(p, o, d, e);
    end
    n_tests++;
    if (full !== 1'b1 || rx_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_full: full=%b rdy=%b, want 1 0", full, rx_tready);
    end
    rx_tdata = 32'h1FF; tx_tready = 1'b1;
    tick(p, o, d, e);
    rx_tvalid = 1'b0;
    n_tests++;
    if (count !== CW'(3) || rx_tready !== 1'b1 || p || d !== 32'h101) begin
      n_fail++;
      $display("FAIL simul_full_pop: count=%0d rdy=%b push=%b popped=%h, want 3 1 0 101",
               count, rx_tready, p, d);
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      tick(p, o, d, e);
      if (o) begin
        n_tests++;
        if (d !== e) begin
          n_fail++;
          $display("FAIL simul_drain: got %h, want %h", d, e);
        end
      end
    end
    tx_tready = 1'b0;
    $display("[TB] test_simul done");
  endtask

  task automatic test_random();
    bit p, o;
    logic [DW-1:0] d, e;
    int snd, rcv, cyc;
    snd = 0; rcv = 0; cyc = 0;
    rx_tvalid = 1'b0;
    while (rcv < 1000 && cyc < 20000) begin
      if (!rx_tvalid) begin
        rx_tvalid = (snd < 1000) && ($urandom_range(0, 1) == 1);
        rx_tdata  = DW'(snd);
      end
      tx_tready = ($urandom_range(0, 1) == 1);
      tick(p, o, d, e);
      cyc++;
      if (p) begin
        snd++;
        rx_tvalid = 1'b0;
      end
      if (o) begin
        n_tests++;
        if (d !== DW'(rcv)) begin
          n_fail++;
          $display("FAIL rand_data idx=%0d: got %0d, want %0d", rcv, d, rcv);
        end
        rcv++;
      end
      n_tests++;
      if (count !== CW'(q.size()) || count > CW'(DEPTH) || rx_tready !== m_rx_rdy() ||
          tx_tvalid !== m_tx_vld() || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_status cyc=%0d: count=%0d rdy=%b vld=%b full=%b empty=%b, want count=%0d rdy=%b vld=%b",
                 cyc, count, rx_tready, tx_tvalid, full, empty, q.size(), m_rx_rdy(), m_tx_vld());
      end
    end
    n_tests++;
    if (rcv != 1000) begin
      n_fail++;
      $display("FAIL rand_timeout: received %0d words, want 1000", rcv);
    end
    rx_tvalid = 1'b0; tx_tready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick(p, o, d, e);
    tx_tready = 1'b0;
    $display("[TB] test_random done: %0d words in %0d cycles", rcv, cyc);
  endtask

  task automatic test_reset_mid();
    bit p, o;
    logic [DW-1:0] d, e;
    bit seen;
    tx_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_tvalid = 1'b1; rx_tdata = 32'h300 + DW'(i);
      tick(p, o, d, e);
    end
    rst = 1'b1; tx_tready = 1'b1;
    tick(p, o, d, e);
    n_tests++;
    if (count !== '0 || tx_tvalid !== 1'b0 || rx_tready !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: count=%0d vld=%b rdy=%b empty=%b, want 0 0 0 1", count, tx_tvalid, rx_tready, empty);
    end
    rst = 1'b0; rx_tvalid = 1'b0;
    tick(p, o, d, e);
    rx_tvalid = 1'b1; rx_tdata = 32'hA5A5A5A5;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick(p, o, d, e);
      if (p) rx_tvalid = 1'b0;
      if (o) begin
        seen = 1'b1;
        n_tests++;
        if (d !== 32'hA5A5A5A5) begin
          n_fail++;
          $display("FAIL reset_mid_first: got %h, want a5a5a5a5", d);
        end
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset_mid_timeout: no word delivered after reset");
    end
    rx_tvalid = 1'b0; tx_tready = 1'b0;
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; rx_tvalid = 1'b0; tx_tready = 1'b0; rx_tdata = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_simul();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
